// File: rtl/uart_regbridge.sv
// Byte-command parser between uart_rx and uart_tx. It turns 'W' addr data and 'R' addr into single register-bus accesses.
// Define UART_REGBRIDGE_ACK_EN to answer every completed write with 'K'.
module uart_regbridge #(
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int TIMER_W        = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_write_o,
  input  logic       tx_busy_i,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       timeout_o,
  output logic       overrun_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    EXEC,
    READ,
    RESP
  } state_t;

  localparam logic [7:0]         OP_WRITE   = 8'h57;
  localparam logic [7:0]         OP_READ    = 8'h52;
  localparam logic [7:0]         RESP_UNK   = 8'h3F;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic               op_write;
  logic               read_wait;
  logic [7:0]         resp;
  logic [TIMER_W-1:0] timer;

  assign busy_o = (state != IDLE);

  // Strobes default low every cycle, so each one set below lasts exactly one clock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_write    <= 1'b0;
      read_wait   <= 1'b0;
      resp        <= 8'h00;
      timer       <= '0;
      tx_data_o   <= 8'h00;
      tx_write_o  <= 1'b0;
      reg_addr_o  <= 8'h00;
      reg_wdata_o <= 8'h00;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      timeout_o   <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      tx_write_o <= 1'b0;
      reg_we_o   <= 1'b0;
      reg_re_o   <= 1'b0;
      timeout_o  <= 1'b0;
      overrun_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
              op_write <= (rx_data_i == OP_WRITE);
              timer    <= '0;
              state    <= ADDR;
            end else begin
              resp  <= RESP_UNK;
              state <= RESP;
            end
          end
        end
        ADDR: begin
          if (rx_valid_i) begin
            reg_addr_o <= rx_data_i;
            timer      <= '0;
            if (op_write) begin
              state <= DATA;
            end else begin
              reg_re_o  <= 1'b1;
              read_wait <= 1'b1;
              state     <= READ;
            end
          end else if (timer == TIMER_LAST) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            reg_wdata_o <= rx_data_i;
            reg_we_o    <= 1'b1;
            timer       <= '0;
            state       <= EXEC;
          end else if (timer == TIMER_LAST) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EXEC: begin
          overrun_o <= rx_valid_i;
`ifdef UART_REGBRIDGE_ACK_EN
          resp  <= 8'h4B;
          state <= RESP;
`else
          state <= IDLE;
`endif
        end
        READ: begin
          overrun_o <= rx_valid_i;
          // Read data arrives one clock after the strobe; send it straight out if the transmitter is free.
          if (read_wait) begin
            read_wait <= 1'b0;
          end else begin
            resp <= reg_rdata_i;
            if (!tx_busy_i) begin
              tx_data_o  <= reg_rdata_i;
              tx_write_o <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          overrun_o <= rx_valid_i;
          if (!tx_busy_i) begin
            tx_data_o  <= resp;
            tx_write_o <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
